stream_front_end: RTL and testbench

- Input stage of the stream coprocessor wrapper. It accepts an AXI4-Stream slave input from DMA and buffers the words in a small FIFO.
- It presents the buffered words to the first dataflow actor using the send/rdy/ack protocol.
- It sits directly upstream of the actor network, mirroring the output-side stage.
- Each transfer moves exactly `size` words and is framed by `start`. `done` is asserted when every word has been delivered to the actor.

---
 rtl/stream_front_end.sv | 184 ++++++++++++++++++
 tb/tb_stream_front_end.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_front_end.sv
// stream_front_end: AXI4-Stream slave input stage feeding the first dataflow
// actor. Accepted beats are buffered in a small FIFO and presented to the
// actor with the send/rdy/ack handshake. Each transfer moves exactly `size`
// words and is framed by the `start` level; `done` reports full delivery.
module stream_front_end #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 2,
  parameter int SIZE_W     = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [SIZE_W-1:0] size,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_send,
  input  logic              out_rdy,
  input  logic              out_ack,
  output logic              done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;

  localparam logic [SIZE_W-1:0] CNT_ZERO = {SIZE_W{1'b0}};
  localparam logic [SIZE_W-1:0] CNT_ONE  = {{(SIZE_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WORK = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SIZE_W-1:0] len_q, len_d;
  logic [SIZE_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [SIZE_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic              ready_s;
  logic              push_s;
  logic              pop_s;
  logic [DATA_W-1:0] head_s;

  // The actor's rdy is informational only; the pop decision uses ack alone.
  logic unused_out_rdy_s;
  assign unused_out_rdy_s = out_rdy;

  // FIFO status from the extended pointers: equal means empty, equal index
  // with differing wrap bit means full.
  always_comb begin
    fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    fifo_full_s  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    head_s       = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  end

  // Next-state, counter, pointer and handshake logic for the transfer FSM.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rx_cnt_d = rx_cnt_q;
    tx_cnt_d = tx_cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ready_s  = 1'b0;
    push_s   = 1'b0;
    pop_s    = 1'b0;
    out_send = 1'b0;
    out_data = DATA_ZERO;
    done     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d    = size;
          rx_cnt_d = CNT_ZERO;
          tx_cnt_d = CNT_ZERO;
          wr_ptr_d = PTR_ZERO;
          rd_ptr_d = PTR_ZERO;
          if (size == CNT_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WORK;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WORK: begin
        // Ready is a function of registers only, so no input-to-output path.
        ready_s  = !fifo_full_s && (rx_cnt_q != len_q);
        out_send = !fifo_empty_s;
        out_data = fifo_empty_s ? DATA_ZERO : head_s;
        if (!start) begin
          // Abort: drop buffered words and any beat offered this cycle.
          state_d  = ST_IDLE;
          rx_cnt_d = CNT_ZERO;
          tx_cnt_d = CNT_ZERO;
          wr_ptr_d = PTR_ZERO;
          rd_ptr_d = PTR_ZERO;
        end else begin
          push_s = s_tvalid && ready_s;
          pop_s  = out_ack && !fifo_empty_s;
          if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            rx_cnt_d = rx_cnt_q + CNT_ONE;
          end else begin
            wr_ptr_d = wr_ptr_q;
            rx_cnt_d = rx_cnt_q;
          end
          if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            tx_cnt_d = tx_cnt_q + CNT_ONE;
          end else begin
            rd_ptr_d = rd_ptr_q;
            tx_cnt_d = tx_cnt_q;
          end
          if (pop_s && ((tx_cnt_q + CNT_ONE) == len_q)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WORK;
          end
        end
      end

      ST_DONE: begin
        done = 1'b1;
        if (!start) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s_tready = ready_s;

  // State, length, counter and pointer registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      len_q    <= CNT_ZERO;
      rx_cnt_q <= CNT_ZERO;
      tx_cnt_q <= CNT_ZERO;
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; written on an accepted beat at the current write index.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_ZERO;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= s_tdata;
    end
  end

endmodule

// File: tb/tb_stream_front_end.sv
// Testbench for stream_front_end: scenario tasks compare the DUT each cycle
// against a queue-based transfer model and check delivered word order.
module tb_stream_front_end;

  localparam int DW    = 32;
  localparam int DL    = 2;
  localparam int SW    = 16;
  localparam int DEPTH = 4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          start;
  logic [SW-1:0] size;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] out_data;
  logic          out_send;
  logic          out_rdy;
  logic          out_ack;
  logic          done;

  stream_front_end #(.DATA_W(DW), .DEPTH_LOG2(DL), .SIZE_W(SW)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .size(size),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .out_data(out_data), .out_send(out_send), .out_rdy(out_rdy),
    .out_ack(out_ack), .done(done)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  // Transfer model: phase 0 idle, 1 working, 2 complete.
  int            m_phase;
  int            m_len, m_rx, m_tx;
  logic [DW-1:0] m_q[$];

  logic [DW-1:0] rx_log[$];
  logic [DW-1:0] tx_log[$];
  int            hs_cnt = 0;
  bit            hs_last = 1'b0;
  logic [DW+2:0] ev, ov;

  function automatic logic [DW+2:0] exp_vec();
    logic rdy, snd, dn;
    logic [DW-1:0] d;
    snd = (m_phase == 1) && (m_q.size() > 0);
    rdy = (m_phase == 1) && (m_q.size() < DEPTH) && (m_rx != m_len);
    dn  = (m_phase == 2);
    d   = snd ? m_q[0] : {DW{1'b0}};
    return {rdy, snd, dn, d};
  endfunction

  function automatic void m_reset();
    m_phase = 0; m_len = 0; m_rx = 0; m_tx = 0;
    m_q.delete();
  endfunction

  function automatic void m_update();
    bit rdy, pop, push;
    case (m_phase)
      0: if (start) begin
           m_len = int'(size); m_rx = 0; m_tx = 0; m_q.delete();
           m_phase = (size == 16'd0) ? 2 : 1;
         end
      1: if (!start) begin
           m_phase = 0; m_q.delete(); m_rx = 0; m_tx = 0;
         end else begin
           rdy  = (m_q.size() < DEPTH) && (m_rx != m_len);
           pop  = out_ack && (m_q.size() > 0);
           push = s_tvalid && rdy;
           if (pop) begin void'(m_q.pop_front()); m_tx++; end
           if (push) begin m_q.push_back(s_tdata); m_rx++; end
           if (pop && m_tx == m_len) m_phase = 2;
         end
      default: if (!start) m_phase = 0;
    endcase
  endfunction

  // Called at the negedge after sampling: log handshakes, advance the model,
  // then move to just after the next rising edge.
  task automatic step();
    hs_last = s_tvalid && s_tready;
    if (hs_last) begin hs_cnt++; tx_log.push_back(s_tdata); end
    if (out_ack && out_send) rx_log.push_back(out_data);
    m_update();
    @(posedge aclk); #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; start = 1'b0; size = 16'd0; s_tdata = 32'd0;
    s_tvalid = 1'b0; out_ack = 1'b0; out_rdy = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if ({s_tready, out_send, done, out_data} !== {(DW+3){1'b0}}) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {s_tready, out_send, done, out_data});
    end
    aresetn = 1'b1;
    m_reset();
    @(posedge aclk); #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge aclk);
      ev = exp_vec(); ov = {s_tready, out_send, done, (ev[DW+1] ? out_data : {DW{1'b0}})};
      checks++;
      if (ov !== ev) begin failures++; $display("FAIL reset_idle t=%0t got=%h want=%h", $time, ov, ev); end
      step();
    end
  endtask

  task automatic test_basic();
    int hs0;
    hs0 = hs_cnt; rx_log.delete();
    start = 1'b1; size = 16'd8; s_tvalid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      s_tdata = DW'(hs_cnt - hs0);
      out_ack = out_send;
      @(negedge aclk);
      ev = exp_vec(); ov = {s_tready, out_send, done, (ev[DW+1] ? out_data : {DW{1'b0}})};
      checks++;
      if (ov !== ev) begin failures++; $display("FAIL basic t=%0t got=%h want=%h", $time, ov, ev); end
      step();
    end
    checks++;
    if (rx_log.size() != 8) begin failures++; $display("FAIL basic_count got=%0d want=8", rx_log.size()); end
    for (int i = 0; i < 8 && i < rx_log.size(); i++) begin
      checks++;
      if (rx_log[i] !== DW'(i)) begin failures++; $display("FAIL basic_order[%0d] got=%h want=%h", i, rx_log[i], DW'(i)); end
    end
    checks++;
    if (hs_cnt - hs0 != 8) begin failures++; $display("FAIL basic_accepted got=%0d want=8", hs_cnt - hs0); end
    checks++;
    if ({done, s_tready} !== 2'b10) begin failures++; $display("FAIL basic_done got=%b want=10", {done, s_tready}); end
    start = 1'b0; s_tvalid = 1'b0; out_ack = 1'b0;
    @(negedge aclk);
    ev = exp_vec(); ov = {s_tready, out_send, done, (ev[DW+1] ? out_data : {DW{1'b0}})};
    checks++;
    if (ov !== ev) begin failures++; $display("FAIL basic_end got=%h want=%h", ov, ev); end
    step();
  endtask

  task automatic test_backpressure();
    int hs0;
    hs0 = hs_cnt; rx_log.delete();
    start = 1'b1; size = 16'd10; s_tvalid = 1'b1; out_ack = 1'b0;
    for (int c = 0; c < 20; c++) begin
      s_tdata = 32'd100 + DW'(hs_cnt - hs0);
      @(negedge aclk);
      ev = exp_vec(); ov = {s_tready, out_send, done, (ev[DW+1] ? out_data : {DW{1'b0}})};
      checks++;
      if (ov !== ev) begin failures++; $display("FAIL bp_fill t=%0t got=%h want=%h", $time, ov, ev); end
      step();
    end
    checks++;
    if (hs_cnt - hs0 != 4 || s_tready !== 1'b0) begin
      failures++; $display("FAIL bp_full accepted=%0d tready=%b want 4,0", hs_cnt - hs0, s_tready);
    end
    for (int c = 0; c < 30; c++) begin
      s_tdata = 32'd100 + DW'(hs_cnt - hs0);
      out_ack = out_send;
      @(negedge aclk);
      ev = exp_vec(); ov = {s_tready, out_send, done, (ev[DW+1] ? out_data : {DW{1'b0}})};
      checks++;
      if (ov !== ev) begin failures++; $display("FAIL bp_drain t=%0t got=%h want=%h", $time, ov, ev); end
      step();
    end
    checks++;
    if (rx_log.size() != 10) begin failures++; $display("FAIL bp_count got=%0d want=10", rx_log.size()); end
    for (int i = 0; i < 10 && i < rx_log.size(); i++) begin
      checks++;
      if (rx_log[i] !== 32'd100 + DW'(i)) begin failures++; $display("FAIL bp_order[%0d] got=%h want=%h", i, rx_log[i], 32'd100 + DW'(i)); end
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL bp_done got=%b want=1", done); end
    start = 1'b0; s_tvalid = 1'b0; out_ack = 1'b0;
    @(negedge aclk);
    step();
  endtask

  task automatic test_full_pushpop();
    int hs0;
    hs0 = hs_cnt; rx_log.delete();
    start = 1'b1; size = 16'd6; s_tvalid = 1'b1; out_ack = 1'b0;
    for (int c = 0; c < 8; c++) begin
      s_tdata = 32'd200 + DW'(hs_cnt - hs0);
      @(negedge aclk);
      ev = exp_vec(); ov = {s_tready, out_send, done, (ev[DW+1] ? out_data : {DW{1'b0}})};
      checks++;
      if (ov !== ev) begin failures++; $display("FAIL full_fill t=%0t got=%h want=%h", $time, ov, ev); end
      step();
    end
    s_tdata = 32'd204; out_ack = 1'b1;
    @(negedge aclk);
    checks++;
    if ({s_tready, out_send, out_data} !== {2'b01, 32'd200}) begin
      failures++; $display("FAIL full_same_cycle got=%b%b/%h want=01/000000c8", s_tready, out_send, out_data);
    end
    step();
    out_ack = 1'b0;
    @(negedge aclk);
    checks++;
    if (s_tready !== 1'b1 || hs_cnt - hs0 != 4) begin
      failures++; $display("FAIL full_ready_rise tready=%b accepted=%0d want 1,4", s_tready, hs_cnt - hs0);
    end
    step();
    for (int c = 0; c < 20; c++) begin
      s_tdata = 32'd200 + DW'(hs_cnt - hs0);
      out_ack = out_send;
      @(negedge aclk);
      ev = exp_vec(); ov = {s_tready, out_send, done, (ev[DW+1] ? out_data : {DW{1'b0}})};
      checks++;
      if (ov !== ev) begin failures++; $display("FAIL full_drain t=%0t got=%h want=%h", $time, ov, ev); end
      step();
    end
    checks++;
    if (rx_log.size() != 6 || done !== 1'b1) begin failures++; $display("FAIL full_count got=%0d done=%b want 6,1", rx_log.size(), done); end
    for (int i = 0; i < 6 && i < rx_log.size(); i++) begin
      checks++;
      if (rx_log[i] !== 32'd200 + DW'(i)) begin failures++; $display("FAIL full_order[%0d] got=%h want=%h", i, rx_log[i], 32'd200 + DW'(i)); end
    end
    start = 1'b0; s_tvalid = 1'b0; out_ack = 1'b0;
    @(negedge aclk);
    step();
  endtask

  task automatic test_zero_restart();
    int hs0;
    hs0 = hs_cnt;
    start = 1'b1; size = 16'd0; s_tvalid = 1'b1; s_tdata = 32'hdead_beef; out_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      ev = exp_vec(); ov = {s_tready, out_send, done, (ev[DW+1] ? out_data : {DW{1'b0}})};
      checks++;
      if (ov !== ev) begin failures++; $display("FAIL zero t=%0t got=%h want=%h", $time, ov, ev); end
      step();
    end
    checks++;
    if (hs_cnt != hs0 || done !== 1'b1) begin failures++; $display("FAIL zero_done accepted=%0d done=%b want 0,1", hs_cnt - hs0, done); end
    start = 1'b0; s_tvalid = 1'b0;
    @(negedge aclk);
    step();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL zero_idle done=%b want=0", done); end
    hs0 = hs_cnt; rx_log.delete();
    start = 1'b1; size = 16'd3; s_tvalid = 1'b1;
    for (int c = 0; c < 15; c++) begin
      s_tdata = 32'd300 + DW'(hs_cnt - hs0);
      out_ack = out_send;
      @(negedge aclk);
      ev = exp_vec(); ov = {s_tready, out_send, done, (ev[DW+1] ? out_data : {DW{1'b0}})};
      checks++;
      if (ov !== ev) begin failures++; $display("FAIL restart t=%0t got=%h want=%h", $time, ov, ev); end
      step();
    end
    checks++;
    if (rx_log.size() != 3 || done !== 1'b1) begin failures++; $display("FAIL restart_count got=%0d done=%b want 3,1", rx_log.size(), done); end
    for (int i = 0; i < 3 && i < rx_log.size(); i++) begin
      checks++;
      if (rx_log[i] !== 32'd300 + DW'(i)) begin failures++; $display("FAIL restart_order[%0d] got=%h want=%h", i, rx_log[i], 32'd300 + DW'(i)); end
    end
    start = 1'b0; s_tvalid = 1'b0; out_ack = 1'b0;
    @(negedge aclk);
    step();
  endtask

  task automatic test_abort();
    int hs0;
    bit reached;
    hs0 = hs_cnt; rx_log.delete(); reached = 1'b0;
    start = 1'b1; size = 16'd16; out_ack = 1'b0;
    for (int c = 0; c < 30 && !reached; c++) begin
      if (hs_cnt - hs0 >= 5 && rx_log.size() >= 2) begin
        reached = 1'b1;
      end else begin
        s_tvalid = (hs_cnt - hs0 < 5);
        s_tdata  = 32'd400 + DW'(hs_cnt - hs0);
        out_ack  = (rx_log.size() < 2) ? out_send : 1'b0;
        @(negedge aclk);
        ev = exp_vec(); ov = {s_tready, out_send, done, (ev[DW+1] ? out_data : {DW{1'b0}})};
        checks++;
        if (ov !== ev) begin failures++; $display("FAIL abort_run t=%0t got=%h want=%h", $time, ov, ev); end
        step();
      end
    end
    checks++;
    if (!reached) begin failures++; $display("FAIL abort_setup pushes=%0d acks=%0d want 5,2", hs_cnt - hs0, rx_log.size()); end
    start = 1'b0; s_tvalid = 1'b0; out_ack = 1'b0;
    @(negedge aclk);
    step();
    checks++;
    if ({s_tready, out_send, done} !== 3'b000) begin failures++; $display("FAIL abort_idle got=%b want=000", {s_tready, out_send, done}); end
    hs0 = hs_cnt; rx_log.delete();
    start = 1'b1; size = 16'd2; s_tvalid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      s_tdata = 32'd500 + DW'(hs_cnt - hs0);
      out_ack = out_send;
      @(negedge aclk);
      ev = exp_vec(); ov = {s_tready, out_send, done, (ev[DW+1] ? out_data : {DW{1'b0}})};
      checks++;
      if (ov !== ev) begin failures++; $display("FAIL abort_new t=%0t got=%h want=%h", $time, ov, ev); end
      step();
    end
    checks++;
    if (rx_log.size() != 2 || done !== 1'b1) begin failures++; $display("FAIL abort_new_count got=%0d done=%b want 2,1", rx_log.size(), done); end
    for (int i = 0; i < 2 && i < rx_log.size(); i++) begin
      checks++;
      if (rx_log[i] !== 32'd500 + DW'(i)) begin failures++; $display("FAIL abort_new_order[%0d] got=%h want=%h", i, rx_log[i], 32'd500 + DW'(i)); end
    end
    start = 1'b0; s_tvalid = 1'b0; out_ack = 1'b0;
    @(negedge aclk);
    step();
  endtask

  task automatic test_async_reset();
    int hs0;
    hs0 = hs_cnt;
    start = 1'b1; size = 16'd8; s_tvalid = 1'b1; out_ack = 1'b0;
    for (int c = 0; c < 20 && (hs_cnt - hs0 < 3); c++) begin
      s_tdata = 32'd600 + DW'(hs_cnt - hs0);
      @(negedge aclk);
      ev = exp_vec(); ov = {s_tready, out_send, done, (ev[DW+1] ? out_data : {DW{1'b0}})};
      checks++;
      if (ov !== ev) begin failures++; $display("FAIL arst_fill t=%0t got=%h want=%h", $time, ov, ev); end
      step();
    end
    s_tvalid = 1'b0;
    checks++;
    if (out_send !== 1'b1 || hs_cnt - hs0 != 3) begin failures++; $display("FAIL arst_setup send=%b accepted=%0d want 1,3", out_send, hs_cnt - hs0); end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({s_tready, out_send, done, out_data} !== {(DW+3){1'b0}}) begin
      failures++; $display("FAIL arst_immediate got=%h want=0", {s_tready, out_send, done, out_data});
    end
    start = 1'b0;
    m_reset();
    @(posedge aclk);
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;
    hs0 = hs_cnt; rx_log.delete();
    for (int c = 0; c < 14; c++) begin
      start = (c >= 2);
      size = 16'd2;
      s_tvalid = (c >= 2);
      s_tdata = 32'd700 + DW'(hs_cnt - hs0);
      out_ack = out_send;
      @(negedge aclk);
      ev = exp_vec(); ov = {s_tready, out_send, done, (ev[DW+1] ? out_data : {DW{1'b0}})};
      checks++;
      if (ov !== ev) begin failures++; $display("FAIL arst_after t=%0t got=%h want=%h", $time, ov, ev); end
      step();
    end
    checks++;
    if (rx_log.size() != 2 || done !== 1'b1) begin failures++; $display("FAIL arst_new_count got=%0d done=%b want 2,1", rx_log.size(), done); end
    for (int i = 0; i < 2 && i < rx_log.size(); i++) begin
      checks++;
      if (rx_log[i] !== 32'd700 + DW'(i)) begin failures++; $display("FAIL arst_new_order[%0d] got=%h want=%h", i, rx_log[i], 32'd700 + DW'(i)); end
    end
    start = 1'b0; s_tvalid = 1'b0; out_ack = 1'b0;
    @(negedge aclk);
    step();
  endtask

  task automatic test_random();
    int sz, cyc;
    for (int t = 0; t < 8; t++) begin
      sz = $urandom_range(0, 12);
      rx_log.delete(); tx_log.delete();
      start = 1'b1; size = SW'(sz); s_tvalid = 1'b0;
      cyc = 0;
      while (cyc == 0 || (m_phase != 2 && cyc < 200)) begin
        if (!s_tvalid || hs_last) begin
          s_tvalid = ($urandom % 4) != 0;
          s_tdata  = $urandom;
        end
        out_ack = $urandom % 2;
        @(negedge aclk);
        ev = exp_vec(); ov = {s_tready, out_send, done, (ev[DW+1] ? out_data : {DW{1'b0}})};
        checks++;
        if (ov !== ev) begin failures++; $display("FAIL random%0d t=%0t got=%h want=%h", t, $time, ov, ev); end
        step();
        cyc++;
      end
      checks++;
      if (done !== 1'b1 || rx_log.size() != sz || tx_log.size() != sz) begin
        failures++; $display("FAIL random%0d_end done=%b rx=%0d tx=%0d want 1,%0d", t, done, rx_log.size(), tx_log.size(), sz);
      end
      for (int i = 0; i < sz && i < rx_log.size() && i < tx_log.size(); i++) begin
        checks++;
        if (rx_log[i] !== tx_log[i]) begin failures++; $display("FAIL random%0d_order[%0d] got=%h want=%h", t, i, rx_log[i], tx_log[i]); end
      end
      start = 1'b0; s_tvalid = 1'b0; out_ack = 1'b0;
      @(negedge aclk);
      step();
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_basic();
    test_backpressure();
    test_full_pushpop();
    test_zero_restart();
    test_abort();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
